// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types and register-file constants.
// Also supplies the writeback-arbiter requester limit and pointer-width helper.
package cpu_types_pkg;

    localparam int unsigned REG_COUNT     = 32;
    localparam int unsigned RF_ARB_MAXREQ = 8;

    typedef logic [31:0]                  word_t;
    typedef logic [$clog2(REG_COUNT)-1:0] regbits_t;

    // Width of an index into n items; never narrower than one bit
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter over N requesters.
// Scans from index ptr upward, wrapping modulo N; the first active request
// wins a one-hot grant. Holding ptr at zero gives fixed lowest-index priority.
module rr_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = ptr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [PW-1:0] idx;
    logic          found;

    // Rotating priority scan starting at ptr
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PW'((32'(ptr) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between NREQ writeback
// sources. Round-robin grant is combinational; the winning write is registered
// one cycle before reaching WEN/wsel/wdat. Writes to x0 are granted but dropped.
// Build option: RF_ARB_FIXED_PRIO_EN removes the rotating pointer and gives
// fixed lowest-index-wins priority.
module rf_wb_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [NREQ-1:0]     req,
    input  regbits_t [NREQ-1:0] req_wsel,
    input  word_t [NREQ-1:0]    req_wdat,
    output logic [NREQ-1:0]     gnt,
    output logic                WEN,
    output regbits_t            wsel,
    output word_t               wdat,
    output logic                wb_pending
);

    localparam int unsigned PW = ptr_width(NREQ);

    logic [PW-1:0]   arb_ptr;
    logic [NREQ-1:0] arb_gnt;
    logic [PW-1:0]   g;
    logic            any_gnt;

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_arb (
        .req (req),
        .ptr (arb_ptr),
        .gnt (arb_gnt)
    );

`ifdef RF_ARB_FIXED_PRIO_EN
    assign arb_ptr = '0;
`else
    logic [PW-1:0] rr_ptr;

    assign arb_ptr = rr_ptr;

    // Next arbitration starts just past the winner; hold when idle
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            rr_ptr <= '0;
        end else if (any_gnt) begin
            rr_ptr <= (g == PW'(NREQ - 1)) ? '0 : g + 1'b1;
        end
    end
`endif

    // Grant is suppressed while reset is asserted
    always_comb begin
        gnt        = nRST ? arb_gnt : '0;
        any_gnt    = |gnt;
        wb_pending = |(req & ~gnt);
    end

    // One-hot grant to winner index
    always_comb begin
        g = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                g = PW'(i);
            end
        end
    end

    // Register the winning write; an x0 destination is consumed without WEN
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            WEN  <= 1'b0;
            wsel <= '0;
            wdat <= '0;
        end else if (any_gnt) begin
            WEN  <= (req_wsel[g] != '0);
            wsel <= req_wsel[g];
            wdat <= req_wdat[g];
        end else begin
            WEN  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter with two requesters.
module tb_rf_wb_arbiter;

    localparam int NREQ = 2;
`ifdef RF_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic                   CLK;
    logic                   nRST;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0][4:0]   req_wsel;
    logic [NREQ-1:0][31:0]  req_wdat;
    logic [NREQ-1:0]        gnt;
    logic                   WEN;
    logic [4:0]             wsel;
    logic [31:0]            wdat;
    logic                   wb_pending;

    int checks   = 0;
    int failures = 0;

    // Reference state: who is favoured next and what the write port should show
    int          m_ptr;
    logic        m_wen;
    logic [4:0]  m_wsel;
    logic [31:0] m_wdat;
    logic [31:0] rf [32];

    rf_wb_arbiter #(.NREQ(NREQ)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .req        (req),
        .req_wsel   (req_wsel),
        .req_wdat   (req_wdat),
        .gnt        (gnt),
        .WEN        (WEN),
        .wsel       (wsel),
        .wdat       (wdat),
        .wb_pending (wb_pending)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Expected grant: first requester found scanning from the favoured index
    function automatic logic [NREQ-1:0] model_gnt(input logic [NREQ-1:0] r, input int ptr);
        int start;
        int idx;
        start = FIXED ? 0 : ptr;
        for (int k = 0; k < NREQ; k++) begin
            idx = (start + k) % NREQ;
            if (r[idx]) return NREQ'(1) << idx;
        end
        return '0;
    endfunction

    task automatic apply(input logic rst_n, input logic [1:0] r,
                         input logic [4:0] s0, input logic [31:0] d0,
                         input logic [4:0] s1, input logic [31:0] d1);
        @(negedge CLK);
        nRST        = rst_n;
        req         = r;
        req_wsel[0] = s0;
        req_wdat[0] = d0;
        req_wsel[1] = s1;
        req_wdat[1] = d1;
        #1;
    endtask

    // Advance one clock, updating the reference model and the register-file image
    task automatic tick();
        logic [NREQ-1:0] eg;
        int gi;
        eg = nRST ? model_gnt(req, m_ptr) : '0;
        @(posedge CLK);
        if (!nRST) begin
            m_wen = 1'b0; m_wsel = '0; m_wdat = '0; m_ptr = 0;
        end else if (eg != '0) begin
            gi     = eg[1] ? 1 : 0;
            m_wen  = (req_wsel[gi] != 5'd0);
            m_wsel = req_wsel[gi];
            m_wdat = req_wdat[gi];
            m_ptr  = (gi + 1) % NREQ;
        end else begin
            m_wen = 1'b0;
        end
        #1;
        if (WEN === 1'b1) rf[wsel] = wdat;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            apply(1'b0, 2'b11, 5'd1, 32'h1, 5'd2, 32'h2);
            checks++;
            if (gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
            tick();
            checks++;
            if (WEN !== 1'b0 || wsel !== 5'd0 || wdat !== 32'd0) begin
                failures++;
                $display("FAIL reset_out: got WEN=%b wsel=%0d wdat=%h expected 0/0/0", WEN, wsel, wdat);
            end
        end
        apply(1'b1, 2'b11, 5'd1, 32'h1, 5'd2, 32'h2);
        checks++;
        if (gnt !== 2'b01) begin failures++; $display("FAIL reset_first_gnt: got %b expected 01", gnt); end
        tick();
        apply(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();
    endtask

    task automatic test_single();
        apply(1'b1, 2'b01, 5'd3, 32'hDEADBEEF, 5'd0, 32'h0);
        checks++;
        if (gnt !== 2'b01) begin failures++; $display("FAIL single_gnt: got %b expected 01", gnt); end
        tick();
        checks++;
        if (WEN !== 1'b1 || wsel !== 5'd3 || wdat !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_out: got WEN=%b wsel=%0d wdat=%h expected 1/3/deadbeef", WEN, wsel, wdat);
        end
        apply(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        checks++;
        if (gnt !== 2'b00 || wb_pending !== 1'b0) begin
            failures++; $display("FAIL single_idle_gnt: got %b/%b expected 00/0", gnt, wb_pending);
        end
        tick();
        checks++;
        if (WEN !== 1'b0 || wsel !== 5'd3 || wdat !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_hold: got WEN=%b wsel=%0d wdat=%h expected 0/3/deadbeef", WEN, wsel, wdat);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [4:0] exp_s [4] = '{5'd5, 5'd6, 5'd5, 5'd6};
        apply(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();
        for (int c = 0; c < 4; c++) begin
            apply(1'b1, 2'b11, 5'd5, 32'h11, 5'd6, 32'h22);
            checks++;
            if (gnt !== exp_g[c] || wb_pending !== 1'b1) begin
                failures++;
                $display("FAIL contention_gnt[%0d]: got %b/%b expected %b/1", c, gnt, wb_pending, exp_g[c]);
            end
            tick();
            checks++;
            if (WEN !== 1'b1 || wsel !== exp_s[c] || wdat !== ((c % 2 == 0) ? 32'h11 : 32'h22)) begin
                failures++;
                $display("FAIL contention_out[%0d]: got WEN=%b wsel=%0d wdat=%h expected 1/%0d", c, WEN, wsel, wdat, exp_s[c]);
            end
        end
    endtask

    task automatic test_fairness();
        int cnt0 = 0;
        int cnt1 = 0;
        for (int c = 0; c < 8; c++) begin
            apply(1'b1, 2'b11, 5'd10, 32'h100 + c, 5'd11, 32'h200 + c);
            if (gnt[0] === 1'b1) cnt0++;
            if (gnt[1] === 1'b1) cnt1++;
            tick();
        end
        checks++;
        if (cnt0 != (FIXED ? 8 : 4) || cnt1 != (FIXED ? 0 : 4)) begin
            failures++;
            $display("FAIL fairness: got %0d/%0d expected %0d/%0d", cnt0, cnt1, FIXED ? 8 : 4, FIXED ? 0 : 4);
        end
        apply(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();
    endtask

    task automatic test_x0_drop();
        apply(1'b1, 2'b10, 5'd0, 32'h0, 5'd0, 32'hFFFFFFFF);
        checks++;
        if (gnt !== 2'b10) begin failures++; $display("FAIL x0_gnt: got %b expected 10", gnt); end
        tick();
        checks++;
        if (WEN !== 1'b0) begin failures++; $display("FAIL x0_wen: got %b expected 0", WEN); end
        apply(1'b1, 2'b11, 5'd1, 32'h1, 5'd2, 32'h2);
        checks++;
        if (gnt !== 2'b01) begin failures++; $display("FAIL x0_ptr_wrap: got %b expected 01", gnt); end
        tick();
        apply(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();
    endtask

    task automatic test_same_target();
        apply(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();
        rf[7] = 32'h0;
        apply(1'b1, 2'b11, 5'd7, 32'hA, 5'd7, 32'hB);
        checks++;
        if (gnt !== 2'b01 || wb_pending !== 1'b1) begin
            failures++; $display("FAIL same_gnt0: got %b/%b expected 01/1", gnt, wb_pending);
        end
        tick();
        checks++;
        if (WEN !== 1'b1 || wsel !== 5'd7 || wdat !== 32'hA) begin
            failures++; $display("FAIL same_first: got WEN=%b wsel=%0d wdat=%h expected 1/7/a", WEN, wsel, wdat);
        end
        apply(1'b1, 2'b10, 5'd0, 32'h0, 5'd7, 32'hB);
        checks++;
        if (gnt !== 2'b10 || wb_pending !== 1'b0) begin
            failures++; $display("FAIL same_gnt1: got %b/%b expected 10/0", gnt, wb_pending);
        end
        tick();
        apply(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();
        checks++;
        if (rf[7] !== 32'hB) begin failures++; $display("FAIL same_readback: got %h expected b", rf[7]); end
    endtask

    task automatic test_mid_reset();
        logic [1:0] exp_g [3];
        exp_g = FIXED ? '{2'b01, 2'b01, 2'b01} : '{2'b01, 2'b10, 2'b01};
        apply(1'b1, 2'b10, 5'd0, 32'h0, 5'd9, 32'h99);
        checks++;
        if (gnt !== 2'b10) begin failures++; $display("FAIL midrst_gnt: got %b expected 10", gnt); end
        tick();
        checks++;
        if (WEN !== 1'b1 || wsel !== 5'd9) begin
            failures++; $display("FAIL midrst_pre: got WEN=%b wsel=%0d expected 1/9", WEN, wsel);
        end
        apply(1'b0, 2'b10, 5'd0, 32'h0, 5'd9, 32'h99);
        tick();
        checks++;
        if (WEN !== 1'b0 || wsel !== 5'd0 || wdat !== 32'd0) begin
            failures++; $display("FAIL midrst_out: got WEN=%b wsel=%0d wdat=%h expected 0/0/0", WEN, wsel, wdat);
        end
        for (int c = 0; c < 3; c++) begin
            apply(1'b1, 2'b11, 5'd12, 32'hC0 + c, 5'd13, 32'hD0 + c);
            checks++;
            if (gnt !== exp_g[c]) begin
                failures++; $display("FAIL midrst_seq[%0d]: got %b expected %b", c, gnt, exp_g[c]);
            end
            tick();
        end
        apply(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();
    endtask

    // Random traffic: each requester keeps its write stable until granted
    task automatic test_random();
        logic [1:0]  pr;
        logic [4:0]  ps [2];
        logic [31:0] pd [2];
        logic [1:0]  eg;
        pr = '0;
        for (int i = 0; i < 2; i++) begin ps[i] = '0; pd[i] = '0; end
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pr[i] && ($urandom_range(0, 3) != 0)) begin
                    pr[i] = 1'b1;
                    ps[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    pd[i] = $urandom;
                end
            end
            apply(1'b1, pr, ps[0], pd[0], ps[1], pd[1]);
            eg = model_gnt(pr, m_ptr);
            checks++;
            if (gnt !== eg || wb_pending !== |(pr & ~eg)) begin
                failures++;
                $display("FAIL rand_gnt[%0d]: got %b/%b expected %b/%b", c, gnt, wb_pending, eg, |(pr & ~eg));
            end
            tick();
            checks++;
            if (WEN !== m_wen || (m_wen && (wsel !== m_wsel || wdat !== m_wdat))) begin
                failures++;
                $display("FAIL rand_out[%0d]: got WEN=%b wsel=%0d wdat=%h expected %b/%0d/%h",
                         c, WEN, wsel, wdat, m_wen, m_wsel, m_wdat);
            end
            pr = pr & ~eg;
        end
        apply(1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        tick();
    endtask

    initial begin
        nRST     = 1'b0;
        req      = '0;
        req_wsel = '0;
        req_wdat = '0;
        m_ptr    = 0;
        m_wen    = 1'b0;
        m_wsel   = '0;
        m_wdat   = '0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_x0_drop();
        test_same_target();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
